// File: rtl/request_unit.sv
`default_nettype none
// ============================================================================
// Module      : request_unit
// Description : Sequences instruction fetch and data read/write requests
//               toward the cache/memory interface, produces the PC-advance
//               pulse, latches halt, counts retired instructions and flags
//               a data access that never receives dhit.
// Revision    : 1.0 - initial release
// ============================================================================
module request_unit #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             MemRd,
    input  logic             MemWr,
    input  logic             halt,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             pcEn,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count
);

    // Last wait-count value that is still allowed to see dhit.
    localparam logic [15:0]      c_WAIT_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DATA  = 2'd1,
        ST_HALT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_rdQ;
    logic             r_wrQ;
    logic [15:0]      r_waitCnt;
    logic [CNT_W-1:0] r_instrCount;
    logic             w_latchReq;
    logic             w_waitInc;
    logic             w_dataDone;

    // State register; reset drops any in-flight data request at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and Moore output decode; pcEn also depends on handshakes.
    always_comb begin
        w_nextState = r_state;
        iREN        = 1'b0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        pcEn        = 1'b0;
        halted      = 1'b0;
        timeout     = 1'b0;
        w_latchReq  = 1'b0;
        w_waitInc   = 1'b0;
        w_dataDone  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    // Halt wins over any memory decode of the same word.
                    if (halt) begin
                        w_nextState = ST_HALT;
                    end else if (MemRd || MemWr) begin
                        w_nextState = ST_DATA;
                        w_latchReq  = 1'b1;
                    end else begin
                        pcEn = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                dREN = r_rdQ;
                dWEN = r_wrQ;
                // dhit on the final allowed cycle still completes normally.
                if (dhit) begin
                    w_nextState = ST_FETCH;
                    pcEn        = 1'b1;
                    w_dataDone  = 1'b1;
                end else if (r_waitCnt == c_WAIT_LIMIT) begin
                    w_nextState = ST_ERR;
                end else begin
                    w_waitInc = 1'b1;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_ERR: begin
                timeout = 1'b1;
            end
            default: begin
                w_nextState = ST_FETCH;
            end
        endcase
    end

    // Request latches, wait counter and retired-instruction counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rdQ        <= 1'b0;
            r_wrQ        <= 1'b0;
            r_waitCnt    <= 16'd0;
            r_instrCount <= '0;
        end else begin
            if (w_latchReq) begin
                // A store takes priority when both decodes are set.
                r_rdQ     <= MemRd & ~MemWr;
                r_wrQ     <= MemWr;
                r_waitCnt <= 16'd0;
            end else if (w_dataDone) begin
                r_rdQ <= 1'b0;
                r_wrQ <= 1'b0;
            end else if (w_waitInc) begin
                r_waitCnt <= r_waitCnt + 16'd1;
            end
            if (pcEn) begin
                r_instrCount <= r_instrCount + c_CNT_ONE;
            end
        end
    end

    assign instr_count = r_instrCount;

endmodule
`default_nettype wire

// File: doc/request_unit.md
Name: request_unit

Overview:
- Sequencing consumer of the decoded control-unit outputs MemRd, MemWr and halt; sits between the control unit and the cache/memory request interface.
- Issues instruction-fetch and data read/write requests, waits on the ihit/dhit handshakes, and produces the PC-advance enable.
- Latches halt and counts retired instructions.
- Detects a stalled data access with a timeout.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 255, cycles spent in DATA without dhit before entering ERR; range 1..65535.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory handshake; fetched word valid this cycle
- dhit  in  1  data memory handshake; read data valid / write accepted this cycle
- MemRd  in  1  control-unit decode of the current instruction: load
- MemWr  in  1  control-unit decode of the current instruction: store
- halt  in  1  control-unit decode of the current instruction: halt
- iREN  out  1  instruction read request
- dREN  out  1  data read request
- dWEN  out  1  data write request
- pcEn  out  1  one-cycle pulse; PC register loads next PC
- halted  out  1  sticky halt indicator
- timeout  out  1  sticky data-access timeout error
- instr_count  out  CNT_W  number of retired instructions

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous and active-low.
- States: FETCH, DATA, HALT, ERR.
- Reset values: state=FETCH, rd_q=0, wr_q=0, wait counter=0, instr_count=0, halted=0, timeout=0.
- During and after reset, iREN=1 (FETCH decode). dREN, dWEN and pcEn are 0.
- Output decode is Moore for iREN/dREN/dWEN/halted/timeout. pcEn is combinational from state and handshakes.
- FETCH:
  - iREN=1; dREN=dWEN=0.
  - MemRd/MemWr/halt are sampled only in a cycle with ihit=1.
  - ihit & halt -> HALT. pcEn=0; not counted. Halt overrides MemRd/MemWr; no data request is issued.
  - ihit & !halt & (MemRd|MemWr) -> DATA. pcEn=0. Latch rd_q=MemRd&!MemWr and wr_q=MemWr; write has priority if both are set. Clear the wait counter.
  - ihit & !halt & !MemRd & !MemWr -> stay in FETCH. pcEn=1 this cycle; instr_count+1.
  - No ihit -> hold; pcEn=0.
  - dhit in FETCH is ignored.
- DATA:
  - iREN=0, dREN=rd_q, dWEN=wr_q; exactly one of dREN/dWEN is 1.
  - dhit -> FETCH. pcEn=1 this cycle; instr_count+1. rd_q/wr_q cleared on transition.
  - No dhit -> wait counter+1. When the counter reaches TIMEOUT-1 with no dhit in that cycle -> ERR.
  - dhit in the same cycle the limit is reached -> completes normally; dhit wins.
  - ihit in DATA is ignored.
- HALT:
  - All requests 0, pcEn=0, halted=1.
  - Absorbing until reset; ihit/dhit ignored.
- ERR:
  - All requests 0, pcEn=0, timeout=1.
  - Absorbing until reset.
- instr_count wraps modulo 2^CNT_W with no saturation and no flag.
- Latency:
  - Non-memory instruction: pcEn in the ihit cycle.
  - Memory instruction: dREN/dWEN asserted from the cycle after ihit; pcEn in the dhit cycle.
  - Minimum 2 cycles per memory instruction.
- Reset mid-operation (any state): next cycle is FETCH with all reset values; in-flight data request dropped immediately (dREN/dWEN fall asynchronously).

Test Plan:
- Reset then ihit=1, MemRd=MemWr=halt=0 for 3 cycles -> iREN=1 throughout, pcEn=1 each cycle, instr_count=3.
- ihit with MemRd=1; dhit after 3 wait cycles -> dREN=1 for 4 cycles, iREN=0 meanwhile, pcEn=1 only in the dhit cycle, instr_count+1, back to FETCH.
- ihit with MemRd=MemWr=1; dhit next cycle -> dWEN=1, dREN=0, pcEn pulse once.
- ihit with halt=1 and MemWr=1 -> HALT: halted=1, iREN=dREN=dWEN=0, count unchanged; later ihit/dhit have no effect.
- TIMEOUT=4: store issued, dhit never arrives -> dWEN=1 for 4 cycles, then timeout=1 and all requests 0. Same setup with dhit on the 4th cycle -> normal completion, timeout=0.
- nRST pulsed low mid-DATA (dREN=1) -> dREN=0 immediately; after release iREN=1, instr_count=0, halted=timeout=0.
